// File: rtl/clock_edge_tracker_pkg.sv
// Shared definitions for the clock edge tracker and the clock divider it pairs with.
package clock_edge_tracker_pkg;

  localparam int DEFAULT_CNT_SIZE = 16;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    HUNT      = 2'd1,
    LOCKED    = 2'd2,
    LOST      = 2'd3
  } tracker_state_e;

endpackage

// File: rtl/edge_sync_detect.sv
// Synchronizes an asynchronous level and emits registered one-cycle rise/fall strobes.
// edge_r/edge_f are the unregistered detections, aligned with the strobe registers' inputs.
module edge_sync_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_in,
  input  logic reset,
  input  logic async_in,
  output logic edge_r,
  output logic edge_f,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_lvl;

  always_comb begin
    sync_lvl = sync_q[SYNC_STAGES-1];
    sync_d   = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d   = sync_lvl;
    edge_r   = sync_lvl & ~prev_q;
    edge_f   = ~sync_lvl & prev_q;
    rise_d   = edge_r;
    fall_d   = edge_f;
  end

  // Clearing the whole chain on reset discards any transition still in flight.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/clock_edge_tracker.sv
// Tracks a slow divided clock in the clock_in domain: edge strobes, half-period
// measurement, lock detection and loss-of-clock timeout.
//   state     | meaning
//   WAIT_EDGE | no reference edge yet; next edge only starts timing
//   HUNT      | measuring, counting consecutive matching half-periods
//   LOCKED    | LOCK_COUNT matches seen; a mismatch returns to HUNT
//   LOST      | no edge for TIMEOUT_CYCLES; next edge restarts timing
module clock_edge_tracker
  import clock_edge_tracker_pkg::*;
#(
  parameter int CNT_SIZE       = DEFAULT_CNT_SIZE,
  parameter int SYNC_STAGES    = 2,
  parameter int TOLERANCE      = 2,
  parameter int LOCK_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic                slow_clk_in,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [CNT_SIZE-1:0] half_period,
  output logic                period_valid,
  output logic                locked,
  output logic                timeout
);

  localparam int                  MATCH_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [MATCH_W-1:0]  LOCK_LAST  = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MATCH_W-1:0]  LOCK_FULL  = MATCH_W'(LOCK_COUNT);
  localparam logic [CNT_SIZE-1:0] TIMEOUT_TC = CNT_SIZE'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_SIZE:0]   TOL_EXT    = (CNT_SIZE + 1)'(TOLERANCE);

  logic edge_r, edge_f, any_edge;

  edge_sync_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync_detect (
    .clock_in  (clock_in),
    .reset     (reset),
    .async_in  (slow_clk_in),
    .edge_r    (edge_r),
    .edge_f    (edge_f),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  tracker_state_e      state_q, state_d;
  logic [CNT_SIZE-1:0] counter_q, counter_d;
  logic [CNT_SIZE-1:0] half_q, half_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic                has_prev_q, has_prev_d;
  logic                pv_q, pv_d;
  logic                locked_q, locked_d;
  logic                timeout_q, timeout_d;

  logic [CNT_SIZE-1:0] meas;
  logic [CNT_SIZE:0]   meas_ext, prev_ext, diff;
  logic                is_match;

  always_comb begin
    any_edge = edge_r | edge_f;
    meas     = counter_q + CNT_SIZE'(1);
    // One extra bit keeps the ordered subtraction free of wrap.
    meas_ext = {1'b0, meas};
    prev_ext = {1'b0, half_q};
    diff     = (meas_ext >= prev_ext) ? (meas_ext - prev_ext) : (prev_ext - meas_ext);
    is_match = has_prev_q && (diff <= TOL_EXT);

    state_d    = state_q;
    counter_d  = (&counter_q) ? counter_q : (counter_q + CNT_SIZE'(1));
    half_d     = half_q;
    match_d    = match_q;
    has_prev_d = has_prev_q;
    pv_d       = 1'b0;
    locked_d   = locked_q;
    timeout_d  = timeout_q;

    if (any_edge) begin
      counter_d = '0;
      unique case (state_q)
        WAIT_EDGE, LOST: begin
          state_d    = HUNT;
          match_d    = '0;
          has_prev_d = 1'b0;
          timeout_d  = 1'b0;
        end
        HUNT, LOCKED: begin
          half_d     = meas;
          pv_d       = 1'b1;
          has_prev_d = 1'b1;
          if (is_match) begin
            if (state_q == HUNT) begin
              if (match_q == LOCK_LAST) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
                match_d  = LOCK_FULL;
              end else begin
                match_d = match_q + MATCH_W'(1);
              end
            end
          end else begin
            match_d  = '0;
            state_d  = HUNT;
            locked_d = 1'b0;
          end
        end
      endcase
    end else if ((state_q != LOST) && (counter_q == TIMEOUT_TC)) begin
      state_d   = LOST;
      timeout_d = 1'b1;
      locked_d  = 1'b0;
      match_d   = '0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q    <= WAIT_EDGE;
      counter_q  <= '0;
      half_q     <= '0;
      match_q    <= '0;
      has_prev_q <= 1'b0;
      pv_q       <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      half_q     <= half_d;
      match_q    <= match_d;
      has_prev_q <= has_prev_d;
      pv_q       <= pv_d;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
    end
  end

  assign half_period  = half_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_clock_edge_tracker.sv
// Bench for clock_edge_tracker: event-level reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized half-periods.
module tb_clock_edge_tracker;

  localparam int CNT = 16;
  localparam int SS  = 2;
  localparam int TOL = 2;
  localparam int LC  = 4;
  localparam int TO  = 4000;

  localparam int S_WAIT = 0, S_HUNT = 1, S_LOCK = 2, S_LOST = 3;

  logic           clock_in = 1'b0;
  logic           reset;
  logic           slow_clk_in;
  logic           rise_pulse, fall_pulse, period_valid, locked, timeout;
  logic [CNT-1:0] half_period;

  clock_edge_tracker #(
    .CNT_SIZE      (CNT),
    .SYNC_STAGES   (SS),
    .TOLERANCE     (TOL),
    .LOCK_COUNT    (LC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .slow_clk_in (slow_clk_in),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .half_period (half_period),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  initial forever #5 clock_in = ~clock_in;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Reference model: input level seen SS+1 cycles late, edges spaced in cycles.
  int cyc = 0;
  bit h[SS+2];
  int m_state, m_last, m_hp, m_match, m_meas;
  bit m_has_prev, m_rise, m_fall, m_pv, m_locked, m_timeout, m_matched;

  always @(posedge clock_in) begin
    cyc++;
    if (reset) begin
      for (int i = 0; i < SS + 2; i++) h[i] = 1'b0;
      m_state = S_WAIT; m_last = cyc; m_hp = 0; m_match = 0; m_has_prev = 1'b0;
      m_rise = 1'b0; m_fall = 1'b0; m_pv = 1'b0; m_locked = 1'b0; m_timeout = 1'b0;
    end else begin
      for (int i = SS + 1; i > 0; i--) h[i] = h[i-1];
      h[0] = slow_clk_in;
      m_rise = h[SS] & ~h[SS+1];
      m_fall = ~h[SS] & h[SS+1];
      m_pv = 1'b0;
      if (m_rise || m_fall) begin
        if (m_state == S_WAIT || m_state == S_LOST) begin
          m_state = S_HUNT; m_has_prev = 1'b0; m_match = 0; m_timeout = 1'b0;
        end else begin
          m_meas = cyc - m_last;
          m_matched = m_has_prev && ((m_meas > m_hp ? m_meas - m_hp : m_hp - m_meas) <= TOL);
          m_hp = m_meas; m_pv = 1'b1; m_has_prev = 1'b1;
          if (m_matched) begin
            m_match++;
            if (m_state == S_HUNT && m_match >= LC) begin m_state = S_LOCK; m_locked = 1'b1; end
          end else begin
            m_match = 0; m_state = S_HUNT; m_locked = 1'b0;
          end
        end
        m_last = cyc;
      end else if (m_state != S_LOST && (cyc - m_last) == TO) begin
        m_state = S_LOST; m_timeout = 1'b1; m_locked = 1'b0; m_match = 0;
      end
    end
  end

  always @(negedge clock_in) begin
    if (cmp_en) begin
      checks++;
      if ({rise_pulse, fall_pulse, period_valid, locked, timeout} !==
          {m_rise, m_fall, m_pv, m_locked, m_timeout} ||
          half_period !== CNT'(m_hp)) begin
        failures++;
        $display("FAIL cycle_model cyc=%0d got r=%b f=%b pv=%b lk=%b to=%b hp=%0d expected r=%b f=%b pv=%b lk=%b to=%b hp=%0d",
                 cyc, rise_pulse, fall_pulse, period_valid, locked, timeout, half_period,
                 m_rise, m_fall, m_pv, m_locked, m_timeout, m_hp);
      end
    end
  end

  // Strobe log for the directed literal checks.
  int ev_cyc[$], ev_pv[$], ev_hp[$], ev_lk[$], ev_to[$];
  int to_cyc = -1;
  int wide = 0;
  bit rise_prev = 1'b0, fall_prev = 1'b0, to_prev = 1'b0;

  always @(negedge clock_in) begin
    if (rise_pulse === 1'b1 || fall_pulse === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_pv.push_back(int'(period_valid));
      ev_hp.push_back(int'(half_period));
      ev_lk.push_back(int'(locked));
      ev_to.push_back(int'(timeout));
    end
    if ((rise_pulse === 1'b1 && rise_prev) || (fall_pulse === 1'b1 && fall_prev)) wide++;
    if (timeout === 1'b1 && !to_prev) to_cyc = cyc;
    rise_prev = (rise_pulse === 1'b1);
    fall_prev = (fall_pulse === 1'b1);
    to_prev   = (timeout === 1'b1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic half(input bit lvl, input int n);
    slow_clk_in = lvl;
    repeat (n) step();
  endtask

  task automatic clear_log();
    ev_cyc.delete(); ev_pv.delete(); ev_hp.delete(); ev_lk.delete(); ev_to.delete();
  endtask

  int c0, last_ev, base, jit, len, longs;

  initial begin
    reset = 1'b1;
    slow_clk_in = 1'b0;
    step();
    cmp_en = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("reset_outputs",
        int'({rise_pulse, fall_pulse, period_valid, locked, timeout, half_period}), 0);

    // Square wave 5/5 from reset.
    clear_log();
    c0 = cyc;
    for (int i = 0; i < 6; i++) begin half(1'b1, 5); half(1'b0, 5); end
    chk("sq_edge_count", ev_cyc.size(), 12);
    chk("sq_first_latency", q_at(ev_cyc, 0) - c0, 3);
    chk("sq_first_no_pv", q_at(ev_pv, 0), 0);
    chk("sq_second_pv", q_at(ev_pv, 1), 1);
    chk("sq_second_hp", q_at(ev_hp, 1), 5);
    chk("sq_last_hp", q_at(ev_hp, 11), 5);
    chk("sq_unlocked_5th", q_at(ev_lk, 4), 0);
    chk("sq_locked_6th", q_at(ev_lk, 5), 1);

    // Alternating 6/4 stays locked; a 9-cycle half drops lock.
    clear_log();
    for (int i = 0; i < 4; i++) begin half(1'b1, 6); half(1'b0, 4); end
    half(1'b1, 9); half(1'b0, 5); half(1'b1, 5);
    chk("alt_edge_count", ev_cyc.size(), 11);
    chk("alt_hp6", q_at(ev_hp, 1), 6);
    chk("alt_hp4", q_at(ev_hp, 2), 4);
    for (int i = 0; i < 9; i++) chk($sformatf("alt_locked%0d", i), q_at(ev_lk, i), 1);
    chk("alt_drop_hp", q_at(ev_hp, 9), 9);
    chk("alt_drop_pv", q_at(ev_pv, 9), 1);
    chk("alt_drop_locked", q_at(ev_lk, 9), 0);

    // Loss of clock.
    last_ev = q_at(ev_cyc, ev_cyc.size() - 1);
    to_cyc = -1;
    repeat (TO + 20) step();
    chk("to_delay", to_cyc - last_ev, TO);
    chk("to_level", int'(timeout), 1);
    chk("to_unlocked", int'(locked), 0);
    clear_log();
    half(1'b0, 7); half(1'b1, 7); half(1'b0, 7);
    chk("to_recover_count", ev_cyc.size(), 3);
    chk("to_recover_no_pv", q_at(ev_pv, 0), 0);
    chk("to_recover_cleared", q_at(ev_to, 0), 0);
    chk("to_recover_next_pv", q_at(ev_pv, 1), 1);
    chk("to_recover_next_hp", q_at(ev_hp, 1), 7);

    // Long half-period.
    reset = 1'b1; step(); reset = 1'b0;
    clear_log();
    to_cyc = -1;
    for (int i = 0; i < 4; i++) begin half(1'b1, 3000); half(1'b0, 3000); end
    chk("long_count", ev_cyc.size(), 8);
    chk("long_first_no_pv", q_at(ev_pv, 0), 0);
    chk("long_hp", q_at(ev_hp, 3), 3000);
    chk("long_unlocked_5th", q_at(ev_lk, 4), 0);
    chk("long_locked_6th", q_at(ev_lk, 5), 1);
    chk("long_no_timeout", to_cyc, -1);

    // Reset while locked, with a pulse still inside the synchronizer.
    slow_clk_in = 1'b1; step();
    slow_clk_in = 1'b0; reset = 1'b1; step();
    reset = 1'b0;
    chk("midreset_outputs",
        int'({rise_pulse, fall_pulse, period_valid, locked, timeout, half_period}), 0);
    clear_log();
    repeat (20) step();
    chk("midreset_no_strobe", ev_cyc.size(), 0);
    clear_log();
    for (int i = 0; i < 4; i++) begin half(1'b1, 5); half(1'b0, 5); end
    chk("midreset_wait_no_pv", q_at(ev_pv, 0), 0);
    chk("midreset_relock", q_at(ev_lk, 5), 1);

    // One-cycle glitch: 7 vs 5 is still within tolerance, the 1-cycle half is not.
    clear_log();
    wide = 0;
    repeat (2) step();
    slow_clk_in = 1'b1; step();
    slow_clk_in = 1'b0; repeat (10) step();
    chk("glitch_count", ev_cyc.size(), 2);
    chk("glitch_spacing", q_at(ev_cyc, 1) - q_at(ev_cyc, 0), 1);
    chk("glitch_tol_edge_locked", q_at(ev_lk, 0), 1);
    chk("glitch_hp1", q_at(ev_hp, 1), 1);
    chk("glitch_unlock", q_at(ev_lk, 1), 0);
    chk("glitch_width", wide, 0);
    clear_log();
    #2 slow_clk_in = 1'b1;
    #1 slow_clk_in = 1'b0;
    repeat (10) step();
    chk("subcycle_glitch_ignored", ev_cyc.size(), 0);

    // Randomized half-periods, glitches, resets and occasional loss of clock.
    longs = 0;
    base = 5; jit = 0;
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) begin
        base = int'($urandom_range(1, 12));
        jit  = int'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 60) == 0) begin reset = 1'b1; step(); reset = 1'b0; end
      if ($urandom_range(0, 30) == 0) begin
        #2 slow_clk_in = ~slow_clk_in;
        #1 slow_clk_in = ~slow_clk_in;
      end
      len = base + int'($urandom_range(0, jit));
      if (longs < 2 && $urandom_range(0, 120) == 0) begin
        len = TO + int'($urandom_range(0, 20));
        longs++;
      end
      slow_clk_in = ~slow_clk_in;
      repeat (len) step();
    end
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
